// File: rtl/cnn_output_requant_fifo_if.sv
// cnn_output_requant_fifo_if: input, output handshake, flow-control and debug signals of the requant FIFO
interface cnn_output_requant_fifo_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic in_valid;
  logic [15:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [7:0] out_data;
  logic [CNT_W-1:0] count;
  logic full;
  logic empty;
  logic overflow;
  logic clr_ovf;
  modport master (
    output in_valid, in_data, out_ready, clr_ovf,
    input out_valid, out_data, count, full, empty, overflow
  );
  modport slave (
    input in_valid, in_data, out_ready, clr_ovf,
    output out_valid, out_data, count, full, empty, overflow
  );
endinterface

// File: rtl/cnn_output_requant_fifo.sv
// cnn_output_requant_fifo: ReLU/shift/saturate requantizer feeding a DEPTH-entry valid/ready FIFO
module cnn_output_requant_fifo #(
  parameter int DEPTH = 16,
  parameter int SHIFT = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  cnn_output_requant_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, cnt_n;
  logic [15:0] v;
  logic [7:0] q, stg_q;
  logic stg_v, full, empty, overflow, pop, push, drop;
  assign v = bus.in_data >> SHIFT;
  assign q = bus.in_data[15] ? 8'd0 : (|v[15:8]) ? 8'hff : v[7:0];
  assign pop = !empty & bus.out_ready;
  assign push = stg_v & (!full | pop);
  assign drop = stg_v & full & !pop;
  // next occupancy; a pop on empty never happens because pop is gated by !empty
  always_comb cnt_n = (push & !pop) ? count + 1'b1 : (pop & !push) ? count - 1'b1 : count;
  // control state: stage valid, pointers, occupancy flags and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (!rst) begin
      stg_v <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      overflow <= 1'b0;
    end else begin
      stg_v <= bus.in_valid;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      count <= cnt_n;
      full <= cnt_n == CNT_W'(DEPTH);
      empty <= cnt_n == '0;
      overflow <= drop | (overflow & !bus.clr_ovf);
    end
  end
  // datapath storage is never reset: staged sample and FIFO memory
  always_ff @(posedge clk) begin
    if (bus.in_valid) stg_q <= q;
    if (push) mem[wr_ptr] <= stg_q;
  end
  assign bus.out_valid = !empty;
  assign bus.out_data = mem[rd_ptr];
  assign bus.count = count;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_cnn_output_requant_fifo.sv
// tb_cnn_output_requant_fifo: directed plan plus random traffic checked against a queue-based model
module tb_cnn_output_requant_fifo;
  localparam int DEPTH = 16;
  localparam int SHIFT = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] mq [$];
  logic m_sv = 1'b0;
  logic [7:0] m_sq = 8'd0;
  logic m_ovf = 1'b0;
  cnn_output_requant_fifo_if #(.DEPTH(DEPTH)) bus ();
  cnn_output_requant_fifo #(.DEPTH(DEPTH), .SHIFT(SHIFT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] quant(input logic [15:0] d);
    int x;
    if (d[15]) return 8'd0;
    x = int'(d) / (1 << SHIFT);
    return x > 255 ? 8'd255 : 8'(x);
  endfunction
  task automatic cyc(input logic iv, input logic [15:0] d, input logic rdy, input logic clr, input logic r);
    logic pop, drop;
    bus.in_valid = iv;
    bus.in_data = d;
    bus.out_ready = rdy;
    bus.clr_ovf = clr;
    rst = r;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_sv = 1'b0;
      m_ovf = 1'b0;
    end else begin
      pop = mq.size() > 0 && rdy;
      drop = m_sv && mq.size() == DEPTH && !pop;
      if (pop) void'(mq.pop_front());
      if (m_sv && !drop) mq.push_back(m_sq);
      m_ovf = drop || (m_ovf && !clr);
      m_sv = iv;
      if (iv) m_sq = quant(d);
    end
    #1;
    chk("valid", bus.out_valid, mq.size() != 0);
    chk("count", bus.count, mq.size());
    chk("full", bus.full, mq.size() == DEPTH);
    chk("empty", bus.empty, mq.size() == 0);
    chk("ovf", bus.overflow, m_ovf);
    if (mq.size() != 0) chk("data", bus.out_data, mq[0]);
  endtask
  function automatic logic [15:0] rnd();
    return $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 4095));
  endfunction
  task automatic drain();
    for (int i = 0; i < DEPTH + 4; i++) cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
  endtask
  initial begin
    logic [15:0] qv [4];
    qv = '{16'h0123, 16'hfff0, 16'h1000, 16'h000f};
    for (int i = 0; i < 2; i++) cyc(1'($urandom), rnd(), 1'($urandom), 1'($urandom), 1'b0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_count", bus.count, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, qv[i], 1'b1, 1'b0, 1'b1);
      if (i == 0) chk("lat1", bus.out_valid, 1'b0);
      if (i == 1) chk("lat2", bus.out_data, 8'h12);
      if (i == 2) chk("q_neg", bus.out_data, 8'h00);
      if (i == 3) chk("q_sat", bus.out_data, 8'hff);
    end
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    chk("q_small", bus.out_data, 8'h00);
    drain();
    for (int k = 1; k <= 17; k++) cyc(1'b1, 16'(k << 4), 1'b0, 1'b0, 1'b1);
    chk("fill_cnt", bus.count, 16);
    chk("fill_full", bus.full, 1'b1);
    chk("fill_ovf0", bus.overflow, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    chk("drop_ovf", bus.overflow, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      chk("drain_ord", bus.out_data, k);
      cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    end
    chk("drain_empty", bus.empty, 1'b1);
    cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) cyc(1'b1, rnd(), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'h0050, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    chk("pp_cnt", bus.count, 16);
    chk("pp_ovf", bus.overflow, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (bus.count == 1) chk("pp_last", bus.out_data, 8'h05);
      cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    end
    for (int k = 1; k <= 17; k++) cyc(1'b1, rnd(), 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    chk("ovf_set", bus.overflow, 1'b1);
    cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    chk("ovf_clr", bus.overflow, 1'b0);
    cyc(1'b1, rnd(), 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    chk("ovf_setwin", bus.overflow, 1'b1);
    drain();
    cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) cyc(1'b1, 16'(k << 4), 1'b0, 1'b0, 1'b1);
    chk("mid_cnt", bus.count, 5);
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_cnt", bus.count, 0);
    chk("mid_rst_empty", bus.empty, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    chk("mid_no_stage", bus.out_valid, 1'b0);
    for (int k = 0; k < 400; k++)
      cyc(1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 99) != 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cnn_output_requant_fifo.md
# cnn_output_requant_fifo

Result collector that sits directly downstream of the CNN accelerator's output buffer. It captures each signed 16-bit max-pooled result, then requantizes it with ReLU, an arithmetic right shift and saturation to unsigned 8 bits. Results are held in a DEPTH-entry FIFO and presented to the next layer or host through a valid/ready handshake. Count, full, empty and a sticky overflow flag are reported for flow control and debug.

## Interface

Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2.
- SHIFT, 4: requantization right-shift amount; legal range 0..8.
- CNT_W, $clog2(DEPTH)+1: width of Count.

Ports:
- Clk  in  1  Single clock; all state changes on rising edge.
- Rst  in  1  Synchronous, active-low reset.
- In_Valid  in  1  In_Data carries a new pooled result this cycle.
- In_Data  in  16  Signed two's-complement pooled result (CNN_OUT).
- Out_Valid  out  1  FIFO head is valid; equals !Empty.
- Out_Ready  in  1  Consumer accepts the head this cycle.
- Out_Data  out  8  Unsigned requantized value at FIFO head.
- Count  out  CNT_W  Number of entries stored (0..DEPTH).
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Overflow  out  1  Sticky; a quantized sample was dropped because the FIFO was full.
- Clr_Ovf  in  1  Clears Overflow.

## Operation

- **Stage 1 (quantize register):** on each edge with In_Valid=1, register q and set stage-valid. Otherwise stage-valid clears.
- **Quantize arithmetic:**
  - If In_Data[15]=1, q=0.
  - Otherwise v = In_Data >> SHIFT (unsigned, 16 bits); q = (v > 255) ? 255 : v[7:0].
- **Stage 2 (FIFO write):**
  - Push = stage-valid.
  - Pop = Out_Valid & Out_Ready.
  - Pop is ignored when Empty.
- **Push with FIFO full:**
  - If Pop is also asserted, both occur; Count is unchanged.
  - Otherwise the sample is dropped and Overflow sets.
- **Push and pop when empty:** only the push occurs; Count becomes 1.
- **Pointers:** rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. Count tracks occupancy independently of the pointers.
- **Out_Data:** combinational read of mem[rd_ptr]. The value is don't-care when Empty, but must be stable while Out_Valid=1 and Out_Ready=0.
- **Overflow precedence:** if an overflow event and Clr_Ovf=1 occur in the same cycle, Overflow ends at 1 (set wins).
- **Reset (Rst=0 at an edge), including mid-operation:**
  - Pointers and Count go to 0; stage-valid and Overflow go to 0.
  - In-flight and stored samples are discarded.
  - FIFO memory contents are not reset.
- **Output reset values:** Out_Valid=0, Count=0, Full=0, Empty=1, Overflow=0, Out_Data=don't-care.

## Timing

- **Latency:** In_Valid sampled at edge N → entry written at edge N+1 → Out_Valid=1 after edge N+1 (2 cycles, FIFO previously empty).
- **Throughput:** one input per cycle sustained; no backpressure to the upstream stage, which has no ready signal. Loss on full is signalled only via Overflow.
- **Pop:** takes effect at the edge where Out_Valid & Out_Ready=1. The next entry appears on Out_Data in the following cycle.
- **Flags:** Count, Full and Empty are registered and reflect state after the same edge as the push or pop.
- **Order:** FIFO order strictly preserved; no reordering or duplication.

## Test plan

1. **Reset:** hold Rst=0 for 2 cycles with random In_Valid/In_Data → Out_Valid=0, Count=0, Empty=1, Full=0, Overflow=0.
2. **Quantize:** SHIFT=4, Out_Ready=1, inputs 16'h0123, 16'hFFF0, 16'h1000, 16'h000F on consecutive cycles.
   - Out_Data sequence: 8'h12, 8'h00, 8'hFF, 8'h00.
   - First Out_Valid appears 2 cycles after the first In_Valid.
3. **Fill and overflow:** Out_Ready=0, inputs (k<<4) for k=1..17 back-to-back.
   - Full=1 and Count=16 after the 16th write.
   - The 17th sample is dropped and Overflow=1.
   - Draining yields 1..16 in order, then Empty=1.
4. **Push and pop at full:** with FIFO full, push 16'h0050 while Out_Ready=1 → Count stays 16, Overflow stays 0, and the last entry read after draining is 8'h05.
5. **Overflow clear:**
   - Clr_Ovf=1 alone → Overflow=0 next cycle.
   - Clr_Ovf=1 in the same cycle as a dropped push → Overflow=1.
6. **Reset mid-stream:** with Count=5 and a sample in stage 1, assert Rst=0 for one cycle → Count=0, Empty=1. The staged sample never appears at the output.
